// File: rtl/ps2_scancode_sequencer_if.sv
// Byte-in / event-out bundle for the PS/2 scancode sequencer.
// The slave modport is the sequencer; the master modport is the receiver/consumer side.
interface ps2_scancode_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       overrun;
  logic       seq_err;

  modport master (
    output rx_data, rx_valid, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break, overrun, seq_err
  );

  modport slave (
    input  rx_data, rx_valid, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break, overrun, seq_err
  );
endinterface

// File: rtl/ps2_scancode_sequencer.sv
// Turns set-2 PS/2 scan bytes into {ext, break, code} key events on a single-entry output register.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the most recent make.
//
//  state        | meaning
//  ST_IDLE      | waiting for the first byte of a key action
//  ST_PFX_E0    | E0 seen, extended code or F0 expected
//  ST_PFX_F0    | F0 seen, break code expected
//  ST_PFX_E0F0  | E0 F0 seen, extended break code expected
//  ST_SKIP_E1   | swallowing the remainder of the Pause sequence
module ps2_scancode_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                     clk,
  input logic                     reset,
  ps2_scancode_sequencer_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PFX_E0   = 3'd1;
  localparam logic [2:0] ST_PFX_F0   = 3'd2;
  localparam logic [2:0] ST_PFX_E0F0 = 3'd3;
  localparam logic [2:0] ST_SKIP_E1  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          evt_valid_q, evt_valid_d;
  logic [7:0]    evt_code_q, evt_code_d;
  logic          evt_ext_q, evt_ext_d;
  logic          evt_brk_q, evt_brk_d;
  logic          overrun_q, overrun_d;
  logic          seq_err_q, seq_err_d;

  logic          done;
  logic          new_ext;
  logic          new_brk;
  logic [7:0]    new_code;
  logic          suppress;
  logic          is_err_byte;
  logic          is_ack_byte;
  logic          is_bad_in_brk;

  assign is_err_byte   = (bus.rx_data == 8'h00) || (bus.rx_data == 8'hFF);
  assign is_ack_byte   = (bus.rx_data == 8'hFA) || (bus.rx_data == 8'hAA) ||
                         (bus.rx_data == 8'hEE) || (bus.rx_data == 8'hFE);
  assign is_bad_in_brk = is_err_byte || (bus.rx_data == 8'hE0) ||
                         (bus.rx_data == 8'hF0) || (bus.rx_data == 8'hE1);

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmr_d     = '0;
    done      = 1'b0;
    new_ext   = 1'b0;
    new_brk   = 1'b0;
    new_code  = bus.rx_data;
    seq_err_d = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == 8'hE0) begin
            state_d = ST_PFX_E0;
          end else if (bus.rx_data == 8'hF0) begin
            state_d = ST_PFX_F0;
          end else if (bus.rx_data == 8'hE1) begin
            state_d = ST_SKIP_E1;
            skip_d  = 3'd7;
          end else if (is_err_byte) begin
            seq_err_d = 1'b1;
          end else if (!is_ack_byte) begin
            done = 1'b1;
          end
        end
        ST_PFX_E0: begin
          if (bus.rx_data == 8'hF0) begin
            state_d = ST_PFX_E0F0;
          end else if (bus.rx_data != 8'hE0) begin
            done    = 1'b1;
            new_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_PFX_F0, ST_PFX_E0F0: begin
          state_d = ST_IDLE;
          if (is_bad_in_brk) begin
            seq_err_d = 1'b1;
          end else begin
            done    = 1'b1;
            new_brk = 1'b1;
            new_ext = (state_q == ST_PFX_E0F0);
          end
        end
        ST_SKIP_E1: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            done     = 1'b1;
            new_code = 8'hE1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is abandoned so a lost byte cannot corrupt the next key.
      if (tmr_q == TMR_LAST) begin
        state_d   = ST_IDLE;
        seq_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       lm_valid_q, lm_valid_d;
  logic       lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       lm_hit;

  assign lm_hit   = lm_valid_q && (lm_ext_q == new_ext) && (lm_code_q == new_code);
  assign suppress = done && !new_brk && lm_hit;

  always_comb begin
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    if (done) begin
      if (new_brk) begin
        if (lm_hit) lm_valid_d = 1'b0;
      end else if (!lm_hit) begin
        lm_valid_d = 1'b1;
        lm_ext_d   = new_ext;
        lm_code_d  = new_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= 8'h00;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    overrun_d   = 1'b0;
    if (done && !suppress) begin
      if (!evt_valid_q || bus.evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = new_code;
        evt_ext_d   = new_ext;
        evt_brk_d   = new_brk;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (evt_valid_q && bus.evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      skip_q      <= 3'd0;
      tmr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      overrun_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmr_q       <= tmr_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
      overrun_q   <= overrun_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_ext   = evt_ext_q;
  assign bus.evt_break = evt_brk_q;
  assign bus.overrun   = overrun_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Scoreboard bench for ps2_scancode_sequencer: directed key sequences, then random bytes and ready.
// Honours PS2_REPEAT_FILTER_EN the same way as the design.
module tb_ps2_scancode_sequencer;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  ps2_scancode_sequencer_if bus();

  ps2_scancode_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  int         ready_mode = 1;
  logic [9:0] exp_q[$];
  bit         m_full;
  bit         exp_ovr;
  bit         exp_err;
  bit         m_ext;
  bit         m_brk;
  int         m_skip;
  int         m_wait;
`ifdef PS2_REPEAT_FILTER_EN
  bit         lm_v;
  logic [8:0] lm;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: prefix flags plus a count of Pause bytes still to swallow.
  task automatic model_byte(input logic [7:0] b, output bit done, output logic [9:0] ev,
                            output bit err);
    done = 1'b0;
    ev   = '0;
    err  = 1'b0;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin
        done = 1'b1;
        ev   = {2'b00, 8'hE1};
      end
    end else if (m_brk) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF}) err = 1'b1;
      else begin
        done = 1'b1;
        ev   = {m_ext, 1'b1, b};
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b != 8'hE0) begin
        done  = 1'b1;
        ev    = {2'b10, b};
        m_ext = 1'b0;
      end
    end else begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) m_skip = 7;
      else if (b inside {8'h00, 8'hFF}) err = 1'b1;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) begin
        done = 1'b1;
        ev   = {2'b00, b};
      end
    end
  endtask

  initial begin : model
    bit         done;
    bit         err;
    bit         supp;
    bit         ovr;
    logic [9:0] ev;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_ext = 0; m_brk = 0; m_skip = 0; m_wait = 0;
        m_full = 0; exp_ovr = 0; exp_err = 0;
        exp_q.delete();
`ifdef PS2_REPEAT_FILTER_EN
        lm_v = 0;
`endif
      end else begin
        done = 0; err = 0; ev = '0; supp = 0; ovr = 0;
        if (bus.rx_valid) begin
          m_wait = 0;
          model_byte(bus.rx_data, done, ev, err);
        end else if (m_ext || m_brk || m_skip > 0) begin
          m_wait++;
          if (m_wait == T) begin
            err = 1; m_ext = 0; m_brk = 0; m_skip = 0; m_wait = 0;
          end
        end
`ifdef PS2_REPEAT_FILTER_EN
        if (done) begin
          if (ev[8]) begin
            if (lm_v && lm == {ev[9], ev[7:0]}) lm_v = 0;
          end else if (lm_v && lm == {ev[9], ev[7:0]}) begin
            supp = 1;
          end else begin
            lm_v = 1;
            lm   = {ev[9], ev[7:0]};
          end
        end
`endif
        if (done && !supp) begin
          if (!m_full || bus.evt_ready) begin
            exp_q.push_back(ev);
            m_full = 1;
          end else begin
            ovr = 1;
          end
        end else if (m_full && bus.evt_ready) begin
          m_full = 0;
        end
        exp_ovr = ovr;
        exp_err = err;
      end
    end
  end

  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("evt_valid", bus.evt_valid, m_full);
        check("overrun", bus.overrun, exp_ovr);
        check("seq_err", bus.seq_err, exp_err);
        if (bus.evt_valid && bus.evt_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL event: got %0h, expected none at %0t",
                     {bus.evt_ext, bus.evt_break, bus.evt_code}, $time);
          end else begin
            e = exp_q.pop_front();
            check("event", {bus.evt_ext, bus.evt_break, bus.evt_code}, e);
          end
        end
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 2) bus.evt_ready = ($urandom_range(0, 9) < 7);
      else bus.evt_ready = (ready_mode == 1);
    end
  end

  // Called at posedge+1; holds the previous byte until the next edge, idles gap cycles, then drives b.
  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; bus.rx_valid = 1'b0; end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst evt_valid", bus.evt_valid, 0);
    check("rst evt_code", bus.evt_code, 0);
    check("rst evt_ext", bus.evt_ext, 0);
    check("rst evt_break", bus.evt_break, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 12) return 8'hE0;
    if (r < 22) return 8'hF0;
    if (r < 25) return 8'hE1;
    if (r < 28) return ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
    if (r < 32) begin
      case ($urandom_range(0, 3))
        0: return 8'hFA;
        1: return 8'hAA;
        2: return 8'hEE;
        default: return 8'hFE;
      endcase
    end
    if (r < 40) return 8'($urandom_range(0, 255));
    case ($urandom_range(0, 4))
      0: return 8'h1C;
      1: return 8'h32;
      2: return 8'h75;
      3: return 8'h14;
      default: return 8'h77;
    endcase
  endfunction

  initial begin : stim
    logic [7:0] pause_seq [8];
    pause_seq[0] = 8'hE1; pause_seq[1] = 8'h14; pause_seq[2] = 8'h77; pause_seq[3] = 8'hE1;
    pause_seq[4] = 8'hF0; pause_seq[5] = 8'h14; pause_seq[6] = 8'hF0; pause_seq[7] = 8'h77;

    reset         = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check_reset_state();

    ready_mode = 1;
    send(8'h1C, 2);
    send(8'hF0, 3); send(8'h1C, 0);
    send(8'hE0, 2); send(8'h75, 1);
    send(8'hE0, 2); send(8'hF0, 0); send(8'h75, 0);
    for (int i = 0; i < 8; i++) send(pause_seq[i], (i == 0) ? 3 : 1);
    idle(3);

    ready_mode = 0;
    send(8'h1C, 2);
    send(8'h32, 2);
    idle(1);
    ready_mode = 1;
    send(8'h32, 0);
    idle(3);

    send(8'hE0, 1);
    idle(T + 3);
    send(8'h1C, 0);
    send(8'hE0, 2);
    idle(T - 2);
    send(8'h75, 0);
    idle(3);

    send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1);
    send(8'hF0, 1); send(8'h1C, 0); send(8'h1C, 1);
    idle(3);

    send(8'hF0, 1);
    do_reset();
    check_reset_state();
    send(8'h1C, 1);
    send(8'hFF, 2);
    idle(3);

    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int gap;
      gap = ($urandom_range(0, 19) == 0) ? T + 2 : $urandom_range(0, 2);
      send(rand_byte(), gap);
    end

    ready_mode = 1;
    idle(T + 5);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
